// File: rtl/kyber_ntt_pkg.sv
// rtl/kyber_ntt_pkg.sv - shared NTT constants, types and the index bit-reversal helper
package kyber_ntt_pkg;

  localparam int unsigned Q        = 3329;
  localparam int unsigned ROOT     = 17;
  localparam int unsigned ROOT_INV = 1175;
  localparam int unsigned R_MOD    = 2285;
  localparam int unsigned N        = 128;
  localparam int unsigned LOGN     = $clog2(N);
  localparam int unsigned W        = 16;

  // Barrett constant m = floor(2^(2W) / Q); with k = 2W the quotient
  // estimate is at most one short for any 2W-bit input.
  localparam int unsigned       BARRETT_K = 2 * W;
  localparam logic [4*W-1:0]    BARRETT_M = (64'd1 << BARRETT_K) / 64'(Q);

  typedef logic [W-1:0]    coeff_t;
  typedef logic [2*W-1:0]  prod_t;
  typedef logic [LOGN-1:0] idx_t;

  typedef enum logic {IDLE, GEN} zgen_state_e;

  // Reverse all LOGN bits of a table index.
  function automatic idx_t bitrev(input idx_t x);
    idx_t r;
    r = '0;
    for (int b = 0; b < int'(LOGN); b++) begin
      r[b] = x[int'(LOGN) - 1 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/zeta_table_gen_if.sv
// rtl/zeta_table_gen_if.sv - control and table read bus of the twiddle generator
interface zeta_table_gen_if;
  import kyber_ntt_pkg::*;

  logic   start;
  logic   inv_mode;
  logic   mont;
  logic   busy;
  logic   done;
  logic   ready;
  logic   rd_en;
  idx_t   rd_addr;
  coeff_t rd_data;
  logic   rd_valid;

  // Generator side
  modport slave (
    input  start, inv_mode, mont, rd_en, rd_addr,
    output busy, done, ready, rd_data, rd_valid
  );

  // Requester / butterfly controller side
  modport master (
    output start, inv_mode, mont, rd_en, rd_addr,
    input  busy, done, ready, rd_data, rd_valid
  );

endinterface

// File: rtl/barrett_reduce.sv
// rtl/barrett_reduce.sv - exact combinational reduction of a 2W-bit value mod Q
module barrett_reduce
  import kyber_ntt_pkg::*;
(
  input  prod_t  x_i,
  output coeff_t r_o
);

  logic [4*W-1:0] prod_m;
  prod_t          q_est;
  prod_t          qx;
  prod_t          r_wide;

  // Quotient estimate is floor(x/Q) or one less, so a single subtract finishes it.
  always_comb begin
    prod_m = {{(2*W){1'b0}}, x_i} * BARRETT_M;
    q_est  = prod_t'(prod_m >> BARRETT_K);
    qx     = prod_t'(q_est * prod_t'(Q));
    r_wide = x_i - qx;
    if (r_wide >= prod_t'(Q)) begin
      r_wide = r_wide - prod_t'(Q);
    end
    r_o = coeff_t'(r_wide);
  end

endmodule

// File: rtl/zeta_table_gen.sv
// rtl/zeta_table_gen.sv - sequential twiddle-factor generator with registered-read table
module zeta_table_gen
  import kyber_ntt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  zeta_table_gen_if.slave    bus
);

  zgen_state_e state_q, state_d;
  idx_t        k_q, k_d;
  coeff_t      acc_q, acc_d;
  coeff_t      root_q, root_d;
  logic        table_valid_q, table_valid_d;
  coeff_t      rd_data_q;
  logic        rd_valid_q;

  coeff_t      mem [N];

  prod_t       product;
  coeff_t      acc_next;
  logic        last_k;
  logic        wr_en;
  idx_t        wr_addr;
  logic        done_c;
  logic        ready_c;
  logic        rd_fire;

  // acc and root are both < Q, so the product fits 2W bits without loss.
  assign product = prod_t'(acc_q) * prod_t'(root_q);

  barrett_reduce u_reduce (
    .x_i (product),
    .r_o (acc_next)
  );

  assign last_k  = (k_q == idx_t'(N - 1));
  assign ready_c = table_valid_q && (state_q == IDLE);
  assign rd_fire = bus.rd_en && ready_c;

  // Generator state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      acc_q         <= '0;
      root_q        <= '0;
      table_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      root_q        <= root_d;
      table_valid_q <= table_valid_d;
    end
  end

  // Next-state logic: accept start in IDLE, step one power per cycle in GEN
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    acc_d         = acc_q;
    root_d        = root_q;
    table_valid_d = table_valid_q;
    wr_en         = 1'b0;
    wr_addr       = bitrev(k_q);
    done_c        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d       = GEN;
          k_d           = '0;
          acc_d         = bus.mont ? coeff_t'(R_MOD) : coeff_t'(1);
          root_d        = bus.inv_mode ? coeff_t'(ROOT_INV) : coeff_t'(ROOT);
          table_valid_d = 1'b0;
        end
      end
      GEN: begin
        wr_en = 1'b1;
        acc_d = acc_next;
        k_d   = k_q + idx_t'(1);
        if (last_k) begin
          done_c        = 1'b1;
          state_d       = IDLE;
          table_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Table write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= acc_q;
    end
  end

  // Registered read port; data holds when a read is refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= mem[bus.rd_addr];
      end
    end
  end

  assign bus.busy     = (state_q == GEN);
  assign bus.done     = done_c;
  assign bus.ready    = ready_c;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
